time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl_pkg.sv | 25 ++
 rtl/time_set_ctrl_btn_edge.sv | 18 +
 rtl/time_set_ctrl.sv | 122 ++++++++++++
 tb/tb_time_set_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_ctrl_pkg.sv
// Shared types and constants for the clock time-setting controller.
package time_set_ctrl_pkg;

  localparam int unsigned H_W = 5;
  localparam int unsigned M_W = 6;
  localparam int unsigned S_W = 6;

  localparam logic [H_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [M_W-1:0] MIN_MAX  = 6'd59;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_e;

  function automatic logic [H_W-1:0] inc_hour(input logic [H_W-1:0] v);
    return (v == HOUR_MAX) ? '0 : v + 5'd1;
  endfunction

  function automatic logic [M_W-1:0] inc_min(input logic [M_W-1:0] v);
    return (v == MIN_MAX) ? '0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_edge.sv
// Rising-edge detector for a synchronized button level: one-cycle pulse per press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_pulse
);

  logic r_level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_level_q <= 1'b0;
    else     r_level_q <= i_level;
  end

  assign o_pulse = i_level & ~r_level_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: RUN -> SET_H -> SET_M -> RUN with shadow edit and load strobe.
// Optional inactivity auto-exit enabled by defining TIME_SET_AUTO_EXIT_EN.
import time_set_ctrl_pkg::*;

module time_set_ctrl #(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick_1hz,
  input  logic           btn_mode,
  input  logic           btn_inc,
  input  logic [H_W-1:0] cur_h,
  input  logic [M_W-1:0] cur_m,
  output logic           run_en,
  output logic           load,
  output logic [H_W-1:0] load_h,
  output logic [M_W-1:0] load_m,
  output logic [S_W-1:0] load_s,
  output logic           blink,
  output logic [1:0]     mode
);

  logic           w_mode_edge;
  logic           w_inc_edge;
  logic           w_timeout;
  state_e         r_state;
  state_e         w_next;
  logic [H_W-1:0] r_shadow_h;
  logic [M_W-1:0] r_shadow_m;
  logic           r_run_en;
  logic           r_load;
  logic           r_blink;

  btn_edge u_mode_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (btn_mode),
    .o_pulse (w_mode_edge)
  );

  btn_edge u_inc_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (btn_inc),
    .o_pulse (w_inc_edge)
  );

`ifdef TIME_SET_AUTO_EXIT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_S + 1);
  logic [CNT_W-1:0] r_idle_cnt;

  // Any button edge restarts the idle count; timeout only fires on an idle tick.
  assign w_timeout = (r_state != RUN) && !w_mode_edge && !w_inc_edge && tick_1hz &&
                     (r_idle_cnt == CNT_W'(TIMEOUT_S - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (r_state == RUN || w_mode_edge || w_inc_edge || w_timeout) begin
      r_idle_cnt <= '0;
    end else if (tick_1hz) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_S == 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    if (w_mode_edge) begin
      case (r_state)
        RUN:     w_next = SET_H;
        SET_H:   w_next = SET_M;
        default: w_next = RUN;
      endcase
    end else if (w_timeout) begin
      w_next = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_shadow_h <= '0;
      r_shadow_m <= '0;
      r_run_en   <= 1'b1;
      r_load     <= 1'b0;
      r_blink    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_run_en <= (w_next == RUN);
      // Only the mode-driven exit from SET_M commits; timeout exit discards the edit.
      r_load   <= w_mode_edge && (r_state == SET_M);

      if (w_mode_edge) begin
        if (r_state == RUN) begin
          r_shadow_h <= cur_h;
          r_shadow_m <= cur_m;
        end
      end else if (w_inc_edge) begin
        if (r_state == SET_H) r_shadow_h <= inc_hour(r_shadow_h);
        if (r_state == SET_M) r_shadow_m <= inc_min(r_shadow_m);
      end

      if (r_state == RUN || w_next == RUN) r_blink <= 1'b0;
      else if (tick_1hz)                   r_blink <= ~r_blink;
    end
  end

  assign run_en = r_run_en;
  assign load   = r_load;
  assign load_h = r_shadow_h;
  assign load_m = r_shadow_m;
  assign load_s = '0;
  assign blink  = r_blink;
  assign mode   = r_state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expectations queued per cycle, monitor compares.
module tb_time_set_ctrl;

  localparam int TO = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_h = '0;
  logic [5:0] cur_m = '0;
  logic       run_en, load, blink;
  logic [4:0] load_h;
  logic [5:0] load_m, load_s;
  logic [1:0] mode;

  time_set_ctrl #(.TIMEOUT_S(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .cur_h    (cur_h),
    .cur_m    (cur_m),
    .run_en   (run_en),
    .load     (load),
    .load_h   (load_h),
    .load_m   (load_m),
    .load_s   (load_s),
    .blink    (blink),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int run_en;
    int load;
    int blink;
    int lh;
    int lm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference model state: 0=run, 1=editing hours, 2=editing minutes
  int st = 0, sh_h = 0, sh_m = 0, bl = 0, e_load = 0, cnt = 0;
  bit pm = 0, pi = 0;
  int exp_loads = 0, mon_loads = 0;
  int mon_last_lh = -1, mon_last_lm = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    st = 0; sh_h = 0; sh_m = 0; bl = 0; e_load = 0; cnt = 0; pm = 0; pi = 0;
  endtask

  task automatic model_step(input bit m, input bit i, input bit t, input int h, input int mi);
    bit me, ie;
    int old;
    me = m && !pm;
    ie = i && !pi;
    pm = m;
    pi = i;
    old = st;
    e_load = 0;
    if (me) begin
      if (st == 0) begin sh_h = h; sh_m = mi; st = 1; end
      else if (st == 1) st = 2;
      else begin st = 0; e_load = 1; exp_loads++; end
    end else if (ie) begin
      if (st == 1) sh_h = (sh_h + 1) % 24;
      else if (st == 2) sh_m = (sh_m + 1) % 60;
    end
`ifdef TIME_SET_AUTO_EXIT_EN
    if (old == 0 || me || ie) cnt = 0;
    else if (t) begin
      cnt++;
      if (cnt == TO) begin st = 0; cnt = 0; end
    end
`endif
    if (old == 0 || st == 0) bl = 0;
    else if (t) bl = 1 - bl;
  endtask

  task automatic push_exp();
    exp_t e;
    e.mode = st; e.run_en = (st == 0) ? 1 : 0; e.load = e_load;
    e.blink = bl; e.lh = sh_h; e.lm = sh_m;
    q.push_back(e);
  endtask

  task automatic cyc(input bit m, input bit i, input bit t, input int h, input int mi);
    @(negedge clk);
    rst = 1'b0; btn_mode = m; btn_inc = i; tick_1hz = t;
    cur_h = 5'(h); cur_m = 6'(mi);
    model_step(m, i, t, h, mi);
    push_exp();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 22, 58);
  endtask

  task automatic press_mode();
    cyc(1, 0, 0, 22, 58);
    cyc(0, 0, 0, 22, 58);
  endtask

  task automatic press_inc();
    cyc(0, 1, 0, 22, 58);
    cyc(0, 0, 0, 22, 58);
  endtask

  task automatic pulse_tick();
    cyc(0, 0, 1, 22, 58);
    cyc(0, 0, 0, 22, 58);
  endtask

  task automatic rcyc();
    @(negedge clk);
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; tick_1hz = 1'b0;
    model_reset();
    push_exp();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("mode", 32'(mode), e.mode);
      chk("run_en", 32'(run_en), e.run_en);
      chk("load", 32'(load), e.load);
      chk("blink", 32'(blink), e.blink);
      chk("load_h", 32'(load_h), e.lh);
      chk("load_m", 32'(load_m), e.lm);
      chk("load_s", 32'(load_s), 0);
      if (load === 1'b1) begin
        mon_loads++;
        mon_last_lh = int'(load_h);
        mon_last_lm = int'(load_m);
      end
    end
  end

  initial begin
    // reset and release
    rcyc(); rcyc(); rcyc();
    idle(3);
    settle();
    chk("reset_run_en", 32'(run_en), 1);
    chk("reset_mode", 32'(mode), 0);

    // 22:58 -> two hour incs, three minute incs -> 00:01
    press_mode();
    press_inc(); press_inc();
    press_mode();
    press_inc(); press_inc(); press_inc();
    press_mode();
    idle(3);
    settle();
    chk("commit_load_h", 32'(mon_last_lh), 0);
    chk("commit_load_m", 32'(mon_last_lm), 1);
    chk("commit_run_en", 32'(run_en), 1);
    chk("commit_loads", 32'(mon_loads), 1);

    // simultaneous mode+inc in SET_H: mode wins
    press_mode();
    press_inc();
    cyc(1, 1, 0, 22, 58);
    cyc(0, 0, 0, 22, 58);
    settle();
    chk("mode_wins_state", 32'(mode), 2);
    chk("mode_wins_hour", 32'(load_h), 23);
    press_mode();
    idle(2);

    // blink toggles on ticks in SET_M, cleared on return to RUN
    press_mode(); press_mode();
    pulse_tick(); pulse_tick(); pulse_tick();
    settle();
    chk("blink_after_3", 32'(blink), 1);
    press_mode();
    idle(2);

    // held inc: one action only
    press_mode();
    for (int k = 0; k < 6; k++) cyc(0, 1, 0, 10, 30);
    cyc(0, 0, 0, 10, 30);
    settle();
    chk("hold_single_inc", 32'(load_h), 23);
    press_mode(); press_mode();
    idle(2);

    // reset while editing minutes: edit discarded
    press_mode(); press_mode(); press_inc();
    rcyc(); rcyc();
    idle(3);
    settle();
    chk("mid_edit_rst_mode", 32'(mode), 0);
    chk("mid_edit_rst_run", 32'(run_en), 1);

    // idle ticks in SET_H
    press_mode();
    for (int k = 1; k < TO; k++) pulse_tick();
    cyc(0, 1, 1, 22, 58);
    cyc(0, 0, 0, 22, 58);
    for (int k = 1; k < TO; k++) pulse_tick();
    settle();
    chk("restart_still_set", 32'(mode), 1);
    pulse_tick();
    settle();
`ifdef TIME_SET_AUTO_EXIT_EN
    chk("timeout_to_run", 32'(mode), 0);
`else
    chk("no_timeout_persist", 32'(mode), 1);
    press_mode(); press_mode();
`endif
    idle(2);

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 149) == 0) rcyc();
      else cyc(($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 5) == 0), int'($urandom_range(0, 23)),
               int'($urandom_range(0, 59)));
    end
    idle(3);
    settle();
    chk("queue_drained", 32'(q.size()), 0);
    chk("load_count", 32'(mon_loads), 32'(exp_loads));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
